hex_display_ctrl: RTL and testbench

Drives a bank of seven-segment HEX displays from one binary value, such as step index or BPM.
- Converts the value to BCD with an iterative double-dabble engine (add-3 / shift).
- Optionally blanks leading zeros and latches the digit codes.
- Feeds one existing `sevenseg` decoder per digit.
- Sits between the sequencer core and the board HEX pins, and sequences conversions so display updates are glitch-free and atomic.

---
 rtl/hex_display_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 rtl/sevenseg.sv | 30 +++
 rtl/hex_display_ctrl.sv | 90 +++++++++
 tb/tb_hex_display_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the HEX display controller.
// Default sizing drives a three-digit 0..999 display from a 10-bit value.
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam int DEF_BIN_W      = 10;
    localparam int DEF_NUM_DIGITS = 3;
    localparam int DEF_MAX_VAL    = 999;
    localparam int DEF_BCD_W      = 4 * DEF_NUM_DIGITS;
    localparam int DEF_CNT_W      = $clog2(DEF_BIN_W + 1);

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep "latest wins" pending slot.
// state   | meaning
// IDLE    | waiting; loads pending or new request, saturating to MAX_VAL
// CONVERT | BIN_W add-3/shift steps, cycle count held in a down-counter
// UPDATE  | one cycle; bcd holds the finished result for the display registers
module bin2bcd_seq
    import hex_display_pkg::*;
#(
    parameter int BIN_W   = DEF_BIN_W,
    parameter int MAX_VAL = DEF_MAX_VAL,
    parameter int BCD_W   = DEF_BCD_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BIN_W-1:0] value,
    input  logic             start,
    input  logic             blank_lz,
    output logic             busy,
    output logic             upd,
    output logic [BCD_W-1:0] bcd,
    output logic             blank,
    output logic             ovf
);

    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [BIN_W-1:0]   bin_q, bin_n;
    logic [BCD_W-1:0]   bcd_q, bcd_n, adj;
    logic               ovf_q, ovf_n;
    logic               blank_q, blank_n;
    logic               pend_q, pend_n;
    logic [BIN_W-1:0]   pend_val_q, pend_val_n;
    logic               pend_blank_q, pend_blank_n;
    logic [BIN_W-1:0]   src_val;
    logic               src_blank;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        bin_n        = bin_q;
        bcd_n        = bcd_q;
        ovf_n        = ovf_q;
        blank_n      = blank_q;
        pend_n       = pend_q;
        pend_val_n   = pend_val_q;
        pend_blank_n = pend_blank_q;
        src_val      = pend_q ? pend_val_q : value;
        src_blank    = pend_q ? pend_blank_q : blank_lz;

        // A start that cannot be taken this cycle parks in the pending slot.
        if (start && (state_q != IDLE || pend_q)) begin
            pend_n       = 1'b1;
            pend_val_n   = value;
            pend_blank_n = blank_lz;
        end

        case (state_q)
            IDLE: begin
                if (start || pend_q) begin
                    bin_n   = (src_val > MAX_BIN) ? MAX_BIN : src_val;
                    ovf_n   = (src_val > MAX_BIN);
                    blank_n = src_blank;
                    bcd_n   = '0;
                    cnt_n   = CNT_LOAD;
                    state_n = CONVERT;
                    if (!start) begin
                        pend_n = 1'b0;
                    end
                end
            end
            CONVERT: begin
                bcd_n = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_n = {bin_q[BIN_W-2:0], 1'b0};
                cnt_n = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_n = UPDATE;
                end
            end
            UPDATE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            blank_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_val_q   <= '0;
            pend_blank_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            bin_q        <= bin_n;
            bcd_q        <= bcd_n;
            ovf_q        <= ovf_n;
            blank_q      <= blank_n;
            pend_q       <= pend_n;
            pend_val_q   <= pend_val_n;
            pend_blank_q <= pend_blank_n;
        end
    end

    assign busy  = (state_q != IDLE);
    assign upd   = (state_q == UPDATE);
    assign bcd   = bcd_q;
    assign blank = blank_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/sevenseg.sv
// Hex digit to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
// Code 4'hF is reserved as the blank code and lights nothing.
module sevenseg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Binary value to multi-digit seven-segment display with optional leading-zero blanking.
// Digit registers load only from a finished conversion, so the pins never show partial results.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int BIN_W      = DEF_BIN_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int MAX_VAL    = DEF_MAX_VAL
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BIN_W-1:0]        value,
    input  logic                    start,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic             upd;
    logic             conv_blank;
    logic             conv_ovf;
    logic [BCD_W-1:0] bcd;
    logic [3:0]       digit_q [NUM_DIGITS];
    logic [3:0]       digit_n [NUM_DIGITS];
    logic             lead;

    bin2bcd_seq #(
        .BIN_W   (BIN_W),
        .MAX_VAL (MAX_VAL),
        .BCD_W   (BCD_W),
        .CNT_W   (CNT_W)
    ) u_bin2bcd_seq (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .start    (start),
        .blank_lz (blank_lz),
        .busy     (busy),
        .upd      (upd),
        .bcd      (bcd),
        .blank    (conv_blank),
        .ovf      (conv_ovf)
    );

    // Blank zeros from the MSD down until the first nonzero; the units digit always shows.
    always_comb begin
        lead = conv_blank;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_n[i] = bcd[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'd0)) begin
                digit_n[i] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= (i == 0) ? 4'd0 : BLANK_CODE;
            end
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= upd;
            if (upd) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digit_q[i] <= digit_n[i];
                end
                overflow <= conv_ovf;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        sevenseg u_sevenseg (
            .digit (digit_q[g]),
            .seg   (seg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: decimal reference model feeds a queue of expected
// displays; a negedge monitor compares every cycle and on each done pulse.
module tb_hex_display_ctrl;

    localparam int BIN_W = 10;
    localparam int MAXV  = 999;
    localparam logic [20:0] RESET_SEG = {7'b1111111, 7'b1111111, 7'b1000000};

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  value;
    logic        start;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [20:0] seg;

    always #5 clock = ~clock;

    hex_display_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .start    (start),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .seg      (seg)
    );

    typedef struct {
        int          at_edge;
        logic [20:0] seg;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          free_edge = 0;
    bit          run = 0;
    bit          pend = 0;
    int          pend_v = 0;
    bit          pend_b = 0;
    bit          exp_busy = 0;
    logic [20:0] cur_seg = RESET_SEG;
    logic        cur_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] render(input int v, input bit b);
        int x;
        int d[3];
        int code[3];
        bit lead;
        x = (v > MAXV) ? MAXV : v;
        d[0] = x % 10;
        d[1] = (x / 10) % 10;
        d[2] = x / 100;
        lead = b;
        code[0] = d[0];
        for (int i = 2; i >= 1; i--) begin
            if (lead && d[i] == 0) code[i] = 10;
            else begin
                code[i] = d[i];
                lead = 0;
            end
        end
        return {seg_of(code[2]), seg_of(code[1]), seg_of(code[0])};
    endfunction

    // A request accepted at edge a is shown after edge a+BIN_W+1; the engine
    // can take the next request at edge a+BIN_W+2.
    task automatic accept(input int v, input bit b);
        exp_t e;
        e.at_edge = edge_n + BIN_W + 1;
        e.seg     = render(v, b);
        e.ovf     = (v > MAXV);
        q.push_back(e);
        free_edge = edge_n + BIN_W + 2;
    endtask

    task automatic model_edge(input bit rst, input bit s, input int v, input bit b);
        if (rst) begin
            pend      = 0;
            free_edge = edge_n + 1;
            q.delete();
            cur_seg   = RESET_SEG;
            cur_ovf   = 1'b0;
        end else if (edge_n >= free_edge) begin
            if (pend) begin
                accept(pend_v, pend_b);
                pend = s;
                if (s) begin
                    pend_v = v;
                    pend_b = b;
                end
            end else if (s) begin
                accept(v, b);
            end
        end else if (s) begin
            pend   = 1;
            pend_v = v;
            pend_b = b;
        end
        exp_busy = (edge_n + 1 < free_edge);
    endtask

    task automatic cyc(input bit rst, input bit s, input int v, input bit b);
        reset    = rst;
        start    = s;
        value    = 10'(v);
        blank_lz = b;
        @(posedge clock);
        edge_n++;
        model_edge(rst, s, v, b);
        run = 1;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    always @(negedge clock) begin
        if (run) begin
            if (q.size() > 0 && q[0].at_edge == edge_n) begin
                exp_t e;
                e = q.pop_front();
                check("done_pulse", 32'(done), 32'd1);
                check("seg_update", 32'(seg), 32'(e.seg));
                check("ovf_update", 32'(overflow), 32'(e.ovf));
                cur_seg = e.seg;
                cur_ovf = e.ovf;
            end else begin
                check("done_quiet", 32'(done), 32'd0);
            end
            check("seg_hold", 32'(seg), 32'(cur_seg));
            check("ovf_hold", 32'(overflow), 32'(cur_ovf));
            check("busy", 32'(busy), 32'(exp_busy));
        end
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        value    = '0;
        blank_lz = 1'b0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_seg", 32'(seg), 32'(RESET_SEG));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        idle(2);

        cyc(0, 1, 123, 0);  idle(14);
        cyc(0, 1, 7, 1);    idle(14);
        cyc(0, 1, 7, 0);    idle(14);
        cyc(0, 1, 1000, 0); idle(14);
        cyc(0, 1, 0, 1);    idle(14);

        cyc(0, 1, 42, 0);
        idle(2);
        cyc(0, 1, 55, 0);
        idle(1);
        cyc(0, 1, 66, 0);
        idle(30);

        // Reset in the fifth CONVERT cycle with a pending request queued behind it.
        cyc(0, 1, 300, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 512, 0);
        idle(2);
        cyc(1, 0, 0, 0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_seg", 32'(seg), 32'(RESET_SEG));
        idle(20);

        repeat (400) begin
            bit r;
            bit s;
            int v;
            bit b;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 5) == 0);
            v = int'($urandom_range(0, 1023));
            b = 1'($urandom_range(0, 1));
            cyc(r, s, v, b);
        end
        idle(40);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
